// File: rtl/reg_dump_unit.sv
// reg_dump_unit: debug reader that walks a contiguous range of CPU register
// file entries through one read port and streams each captured word out,
// tagged with its register index, over a valid/ready interface. The core is
// held (cpu_hold) for the whole walk so no register write can race the dump.
//
// Output handshake: out_valid rises once out_data/out_idx hold a captured
// word. out_valid, out_data and out_idx stay stable until a transfer occurs,
// which is a rising edge with out_valid && out_ready both high. out_valid
// never drops without a transfer, except on abort or rst.
module reg_dump_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] read_reg_num,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done
);

  // Walk phases: READ presents an index to the register file, SEND holds the
  // captured word until it is accepted, DONE emits the single done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX   = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  transfer;
  logic                  last_word;

  // A word leaves the block when the downstream accepts it in SEND.
  assign transfer  = (state == SEND) && out_valid && out_ready;

  // Terminal compare rather than a wrap test, so a range ending at the top
  // index (all ones) stops cleanly instead of rolling over to zero.
  assign last_word = (idx == LAST_IDX);

  // The core stall tracks busy exactly; busy is already a register.
  assign cpu_hold  = busy;

  // Walk FSM with all outputs registered; reset wins over start/abort and
  // abort wins over a simultaneous transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      read_reg_num <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done         <= 1'b0;
          read_reg_num <= '0;
          if (start) begin
            state        <= READ;
            idx          <= FIRST_IDX;
            read_reg_num <= FIRST_IDX;
            busy         <= 1'b1;
          end
        end

        READ: begin
          if (abort) begin
            state        <= IDLE;
            read_reg_num <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
          end else begin
            // read_data is only looked at here; it is combinational for
            // the index presented during this cycle.
            out_data     <= read_data;
            out_idx      <= idx;
            out_valid    <= 1'b1;
            read_reg_num <= '0;
            state        <= SEND;
          end
        end

        SEND: begin
          if (abort) begin
            // The pending word is dropped and counts as not transferred.
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (transfer) begin
            out_valid <= 1'b0;
            if (last_word) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx          <= idx + ONE_IDX;
              read_reg_num <= idx + ONE_IDX;
              state        <= READ;
            end
          end
        end

        DONE: begin
          // Single-cycle pulse; start and abort are both ignored here.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state        <= IDLE;
          read_reg_num <= '0;
          out_valid    <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: a full 0..31 dump, backpressure, an
// ignored restart, reset and abort mid-dump, and a one-register range.
module tb_reg_dump_unit;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0: full range 0..31 ----------------
  logic          start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] read_reg_num, out_idx;
  logic [DW-1:0] read_data, out_data;
  logic          out_valid, busy, cpu_hold, done;
  logic [DW-1:0] regfile [32];

  assign read_data = regfile[read_reg_num];

  reg_dump_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .read_reg_num(read_reg_num), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .cpu_hold(cpu_hold), .done(done)
  );

  // ---------------- DUT 1: single register 5..5 ----------------
  logic          start1 = 1'b0;
  logic [AW-1:0] read_reg_num1, out_idx1;
  logic [DW-1:0] read_data1, out_data1;
  logic          out_valid1, busy1, cpu_hold1, done1;

  assign read_data1 = (read_reg_num1 == 5'd5) ? 32'hDEAD_BEEF : 32'h0000_0000;

  reg_dump_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIRST_REG(5), .LAST_REG(5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
    .read_reg_num(read_reg_num1), .read_data(read_data1),
    .out_valid(out_valid1), .out_ready(1'b1),
    .out_data(out_data1), .out_idx(out_idx1),
    .busy(busy1), .cpu_hold(cpu_hold1), .done(done1)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  int t0 = 0;
  int done_cnt = 0;
  bit chk_time = 1'b0;

  // Every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
    if (!rst && out_valid && out_ready && !abort) begin
      if (exp_q.size() == 0) begin
        check("extra_word", {59'd0, out_idx}, 64'hFFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("xfer_idx", out_idx, e[AW+DW-1:DW]);
        check("xfer_data", out_data, e[DW-1:0]);
        if (chk_time) check("xfer_cycle", cyc - t0, 2 * int'(e[AW+DW-1:DW]) + 2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_q();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back({AW'(i), 32'hA000_0000 + 32'(i)});
  endtask

  // Called just after an edge; the next edge is E0, so cycle 1 follows it.
  task automatic start_dump();
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk); #1;
    end
  endtask

  // Waits for done on DUT 0 with a cycle budget, returns its cycle number.
  task automatic wait_done(output int when);
    bit seen = 1'b0;
    when = -1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        when = cyc - t0;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int when;
    int dc;
    for (int i = 0; i < 32; i++) regfile[i] = 32'hA000_0000 + 32'(i);

    // Reset state
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_read_reg_num", read_reg_num, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;

    // T1: full dump, no backpressure
    fill_q();
    chk_time = 1'b1;
    dc = done_cnt;
    start_dump();
    check("t1_busy_c1", busy, 1);
    check("t1_hold_c1", cpu_hold, 1);
    check("t1_valid_c1", out_valid, 0);
    goto_cycle(3);
    check("t1_read_reg_num_c3", read_reg_num, 1);
    wait_done(when);
    check("t1_done_cycle", when, 65);
    check("t1_busy_at_done", busy, 0);
    check("t1_hold_at_done", cpu_hold, 0);
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);
    check("t1_q_empty", exp_q.size(), 0);
    check("t1_done_count", done_cnt - dc, 1);
    chk_time = 1'b0;
    @(posedge clk); #1;
    idle_cycles(2);

    // T2: out_ready low for 5 cycles at word 7
    fill_q();
    start_dump();
    goto_cycle(16);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_idx", out_idx, 7);
      check("t2_hold_data", out_data, 32'hA000_0007);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(when);
    check("t2_done_cycle", when, 70);
    check("t2_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    idle_cycles(2);

    // T3: start again while SEND at word 3 is ignored
    fill_q();
    dc = done_cnt;
    start_dump();
    goto_cycle(8);
    check("t3_idx_at_restart", out_idx, 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(when);
    check("t3_done_cycle", when, 65);
    idle_cycles(4);
    check("t3_done_count", done_cnt - dc, 1);
    check("t3_q_empty", exp_q.size(), 0);

    // T4: reset with start while SEND at word 10
    fill_q();
    start_dump();
    goto_cycle(22);
    check("t4_idx_before_rst", out_idx, 10);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    check("t4_read_reg_num", read_reg_num, 0);
    check("t4_out_valid", out_valid, 0);
    check("t4_out_data", out_data, 0);
    check("t4_out_idx", out_idx, 0);
    check("t4_busy", busy, 0);
    check("t4_cpu_hold", cpu_hold, 0);
    check("t4_done", done, 0);
    check("t4_q_left", exp_q.size(), 22);
    idle_cycles(3);
    check("t4_stays_idle", busy, 0);
    fill_q();
    start_dump();
    wait_done(when);
    check("t4_restart_done_cycle", when, 65);
    check("t4_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    idle_cycles(2);

    // T5: abort coinciding with the transfer of word 12
    fill_q();
    dc = done_cnt;
    start_dump();
    goto_cycle(26);
    check("t5_idx_at_abort", out_idx, 12);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_q_left", exp_q.size(), 20);
    idle_cycles(4);
    check("t5_no_done_pulse", done_cnt - dc, 0);
    check("t5_stays_idle", busy, 0);
    fill_q();
    start_dump();
    wait_done(when);
    check("t5_restart_done_cycle", when, 65);
    check("t5_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    idle_cycles(2);

    // T6: single-register range on DUT 1
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("t6_read_reg_num_c1", read_reg_num1, 5);
    check("t6_busy_c1", busy1, 1);
    check("t6_valid_c1", out_valid1, 0);
    @(posedge clk); #1;
    check("t6_valid_c2", out_valid1, 1);
    check("t6_idx_c2", out_idx1, 5);
    check("t6_data_c2", out_data1, 32'hDEAD_BEEF);
    check("t6_done_c2", done1, 0);
    @(posedge clk); #1;
    check("t6_done_c3", done1, 1);
    check("t6_busy_c3", busy1, 0);
    check("t6_hold_c3", cpu_hold1, 0);
    check("t6_valid_c3", out_valid1, 0);
    @(posedge clk); #1;
    check("t6_done_c4", done1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
